seq_pattern_detector_param: RTL and testbench

- Parametrised successor to the fixed-pattern Moore serial detector.
- Detects a PAT_W-bit pattern in a gated serial bit stream.
- The pattern is runtime-loadable; overlapping or non-overlapping matching is selectable.
- Drives a registered one-cycle flag per match and a saturating match counter for the host/status logic.

---
 rtl/seq_pattern_detector_param.sv | 90 +++++++++
 tb/tb_seq_pattern_detector_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector_param.sv
// Serial pattern detector with a runtime-loadable PAT_W-bit pattern.
// Detection can be overlapping or non-overlapping. The outputs are a
// registered one-cycle match pulse and a saturating match counter.
module seq_pattern_detector_param #(
    parameter int unsigned      PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1011,
    parameter bit               OVERLAP     = 1'b1,
    parameter int unsigned      CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_in,
    input  logic             valid_in,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    output logic             pattern_flag,
    output logic [CNT_W-1:0] match_count,
    output logic [PAT_W-1:0] cur_pattern
);

    localparam int unsigned      FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

    // FILL while the history is still warming up, ARMED once PAT_W bits are held
    typedef enum logic {
        FILL,
        ARMED
    } state_t;

    state_t             state;
    logic [PAT_W-1:0]   hist_q, hist_nx, hist_sh;
    logic [FILL_W-1:0]  fill_q, fill_nx, fill_inc;
    logic [PAT_W-1:0]   pat_q, pat_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;
    logic               flag_q, flag_nx;
    logic               match;

    // State register: async active-low reset clears history and restores default pattern
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEFAULT_PAT;
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            hist_q <= hist_nx;
            fill_q <= fill_nx;
            pat_q  <= pat_nx;
            cnt_q  <= cnt_nx;
            flag_q <= flag_nx;
        end
    end

    // Next-state: cfg_load beats valid data; idle cycles hold history and counter
    always_comb begin
        hist_sh  = {hist_q[PAT_W-2:0], d_in};
        fill_inc = (state == ARMED) ? FULL : fill_q + 1'b1;
        match    = 1'b0;
        hist_nx  = hist_q;
        fill_nx  = fill_q;
        pat_nx   = pat_q;
        cnt_nx   = cnt_q;
        flag_nx  = 1'b0;
        if (cfg_load) begin
            pat_nx  = cfg_pattern;
            hist_nx = '0;
            fill_nx = '0;
            cnt_nx  = '0;
        end else if (valid_in) begin
            // The fill gate keeps a zero pattern from matching the cleared history
            match   = (fill_inc == FULL) && (hist_sh == pat_q);
            hist_nx = hist_sh;
            flag_nx = match;
            fill_nx = (match && !OVERLAP) ? '0 : fill_inc;
            if (match && (cnt_q != '1)) begin
                cnt_nx = cnt_q + 1'b1;
            end
        end
    end

    // Output/state decode: warm-up state from fill level, ports from registers
    always_comb begin
        state        = (fill_q == FULL) ? ARMED : FILL;
        pattern_flag = flag_q;
        match_count  = cnt_q;
        cur_pattern  = pat_q;
    end

endmodule

// File: tb/tb_seq_pattern_detector_param.sv
// Bench for seq_pattern_detector_param: three instances (overlap, non-overlap,
// 2-bit counter) share one stimulus stream and are checked against a
// bit-stream reference model.
module tb_seq_pattern_detector_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_in;
    logic       valid_in;
    logic       cfg_load;
    logic [3:0] cfg_pattern;

    logic       flag_a, flag_b, flag_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [3:0] pat_a, pat_b, pat_c;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: every accepted bit is kept in order; each instance
    // remembers where its current history begins in that stream.
    bit         stream[$];
    int         start_idx[3];
    int         exp_cnt[3];
    logic       exp_flag[3];
    logic [3:0] exp_pat;
    int         cnt_max[3];
    bit         ovl[3];

    always #5 clk = ~clk;

    seq_pattern_detector_param #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .d_in(d_in), .valid_in(valid_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .pattern_flag(flag_a), .match_count(cnt_a), .cur_pattern(pat_a)
    );

    seq_pattern_detector_param #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .d_in(d_in), .valid_in(valid_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .pattern_flag(flag_b), .match_count(cnt_b), .cur_pattern(pat_b)
    );

    seq_pattern_detector_param #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .d_in(d_in), .valid_in(valid_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .pattern_flag(flag_c), .match_count(cnt_c), .cur_pattern(pat_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("flag_a", 32'(flag_a), 32'(exp_flag[0]));
        chk("flag_b", 32'(flag_b), 32'(exp_flag[1]));
        chk("flag_c", 32'(flag_c), 32'(exp_flag[2]));
        chk("cnt_a",  32'(cnt_a),  32'(exp_cnt[0]));
        chk("cnt_b",  32'(cnt_b),  32'(exp_cnt[1]));
        chk("cnt_c",  32'(cnt_c),  32'(exp_cnt[2]));
        chk("pat_a",  32'(pat_a),  32'(exp_pat));
        chk("pat_b",  32'(pat_b),  32'(exp_pat));
        chk("pat_c",  32'(pat_c),  32'(exp_pat));
    endtask

    // True when the newest four stream bits equal the pattern, oldest bit = MSB
    function automatic bit tail_eq();
        int n = stream.size();
        for (int k = 0; k < 4; k++) begin
            if (stream[n - 4 + k] != exp_pat[3 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_restart(input logic [3:0] p);
        exp_pat = p;
        for (int i = 0; i < 3; i++) begin
            start_idx[i] = stream.size();
            exp_cnt[i]   = 0;
            exp_flag[i]  = 1'b0;
        end
    endtask

    task automatic model_edge(input logic v, input logic d, input logic ld, input logic [3:0] p);
        if (ld) begin
            model_restart(p);
        end else if (v) begin
            stream.push_back(d);
            for (int i = 0; i < 3; i++) begin
                if ((stream.size() - start_idx[i] >= 4) && tail_eq()) begin
                    exp_flag[i] = 1'b1;
                    if (exp_cnt[i] < cnt_max[i]) exp_cnt[i]++;
                    if (!ovl[i]) start_idx[i] = stream.size();
                end else begin
                    exp_flag[i] = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) exp_flag[i] = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic d, input logic ld, input logic [3:0] p);
        valid_in    = v;
        d_in        = d;
        cfg_load    = ld;
        cfg_pattern = p;
        @(posedge clk);
        model_edge(v, d, ld, p);
        #1;
        check_all();
    endtask

    // Pulse reset between clock edges; outputs must clear without a clock
    task automatic async_reset();
        #2;
        reset = 1'b0;
        model_restart(4'b1011);
        #1;
        check_all();
        #1;
        reset = 1'b1;
    endtask

    task automatic bits(input logic [7:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], 1'b0, 4'h0);
    endtask

    initial begin
        cnt_max = '{255, 255, 3};
        ovl     = '{1'b1, 1'b0, 1'b1};
        model_restart(4'b1011);

        reset = 1'b0; valid_in = 1'b0; d_in = 1'b0; cfg_load = 1'b0; cfg_pattern = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // Overlapping vs non-overlapping on 1,0,1,1,0,1,1
        bits(8'b0101_1011, 7);
        chk("ovl_cnt_a", 32'(cnt_a), 32'd2);
        chk("novl_cnt_b", 32'(cnt_b), 32'd1);

        // Valid gaps keep a partial pattern
        async_reset();
        bits(8'b10, 2);
        repeat (3) step(1'b0, 1'b1, 1'b0, 4'hF);
        bits(8'b11, 2);
        chk("gap_flag_a", 32'(flag_a), 32'd1);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        chk("gap_flag_drop", 32'(flag_a), 32'd0);

        // Reload mid-stream; the data bit in the load cycle is dropped
        bits(8'b101, 3);
        step(1'b1, 1'b1, 1'b1, 4'b0000);
        bits(8'b0000, 4);
        chk("reload_pat", 32'(pat_a), 32'd0);
        chk("reload_cnt", 32'(cnt_a), 32'd1);
        step(1'b0, 1'b0, 1'b1, 4'b0000);
        bits(8'b000, 3);
        chk("zero_warmup", 32'(flag_a), 32'd0);

        // Saturation with an all-ones pattern
        step(1'b0, 1'b0, 1'b1, 4'b1111);
        bits(8'hFF, 8);
        chk("sat_cnt_a", 32'(cnt_a), 32'd5);
        chk("sat_cnt_b", 32'(cnt_b), 32'd2);
        chk("sat_cnt_c", 32'(cnt_c), 32'd3);

        // Async reset mid-pattern, then the default pattern matches again
        bits(8'b11, 2);
        async_reset();
        chk("rst_pat", 32'(pat_a), 32'hB);
        bits(8'b1011, 4);
        chk("rst_flag", 32'(flag_a), 32'd1);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                async_reset();
            end else if (r < 6) begin
                step(1'($urandom), 1'($urandom), 1'b1, 4'($urandom));
            end else begin
                step(1'($urandom_range(0, 99) < 75), 1'($urandom), 1'b0, 4'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
